uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095, max cycles waited in WAIT or HOLD before abort (12-bit counter).
REQ-002 SHALL have parameter NREQ, default 4, fixed number of requesters; other values unsupported.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester byte request, level, held until matching ack.
REQ-006 SHALL have port req_data  input  32  byte of requester i on bits [8i+7:8i], stable while req[i]=1.
REQ-007 SHALL have port req_last  input  4  byte from requester i ends its packet; sampled with the byte.
REQ-008 SHALL have port ack  output  4  one-cycle pulse: byte of requester i accepted.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to transmit, valid while tx_start=1 and held until the next load.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy; no tx_start issued while high.
REQ-012 SHALL have port tx_done  input  1  one-cycle pulse: transmitter finished current byte.
REQ-013 SHALL have port owner  output  2  index of the current grant holder.
REQ-014 SHALL have port owner_valid  output  1  high in SEND, WAIT and HOLD.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on abort.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT, HOLD; registered outputs only.
REQ-017 IDLE: when any req=1 and tx_busy=0, SHALL grant the first requester at or after rr_ptr (modulo 4), latch its data and req_last, go to SEND next cycle.
REQ-018 SEND: SHALL assert tx_start=1 and ack[owner]=1 for exactly this one cycle, clear timeout counter, go to WAIT.
REQ-019 WAIT: SHALL count cycles; on tx_done with latched last=1 SHALL set rr_ptr=owner+1 (mod 4) and go to IDLE.
REQ-020 WAIT: on tx_done with latched last=0 SHALL go to HOLD, keep owner (packet lock), clear counter.
REQ-021 HOLD: SHALL ignore all other requesters; when req[owner]=1 and tx_busy=0, latch that byte and go to SEND.
REQ-022 WAIT or HOLD: when counter reaches TIMEOUT, SHALL pulse timeout_err, set rr_ptr=owner+1, go to IDLE.
REQ-023 tx_done and timeout in the same cycle: tx_done SHALL win, no timeout_err.
REQ-024 tx_done while in IDLE, SEND or HOLD SHALL be ignored.
REQ-025 Arbitration latency SHALL be: req rising in IDLE -> tx_start and ack exactly 2 cycles later (IDLE decision edge, SEND edge).
REQ-026 Requests deasserted before ack SHALL be dropped without error; grant evaluated only in IDLE/HOLD.
REQ-027 Counter SHALL saturate at TIMEOUT and never wrap.

Reset
REQ-028 On rst=1, immediately and regardless of state: state=IDLE, rr_ptr=0, owner=0, owner_valid=0, tx_start=0, tx_data=0, ack=0, timeout_err=0, counter=0.
REQ-029 Reset mid-packet SHALL release the lock; after release the first grant SHALL follow rr_ptr=0.

Verification
REQ-030 req=4'b1111, all last=1, tx_done 10 cycles after each tx_start -> grants in order 0,1,2,3,0; ack one-hot one cycle each.
REQ-031 req[2]=1 data 8'hA5 last=1, idle transmitter -> tx_start and ack[2] 2 cycles later, tx_data=8'hA5, owner=2.
REQ-032 req[1] sends 3 bytes (last=0,0,1) while req[0]=req[3]=1 -> all three bytes of requester 1 before any other ack; next grant=3.
REQ-033 grant requester 0, tx_done withheld 4095 cycles -> timeout_err pulse, IDLE, next grant to requester 1; tx_done on cycle 4095 instead -> no error.
REQ-034 tx_busy=1 with req[0]=1 -> no tx_start until tx_busy falls, then tx_start 2 cycles later.
REQ-035 rst asserted in HOLD of requester 3 -> all outputs 0 same cycle; after release req=4'b1001 -> grant 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets four byte sources share one
// UART transmitter. A grant stays with its holder until the byte marked last
// completes (packet lock); a stalled transmitter or a silent holder is aborted
// after TIMEOUT cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req[3:0]          per-requester level request, held until its ack
//   req_data[31:0]    byte of requester i on bits [8i+7:8i]
//   req_last[3:0]     byte of requester i closes its packet
//   ack[3:0]          one-cycle pulse: byte of requester i accepted
//   tx_start          one-cycle load strobe to the transmitter
//   tx_data[7:0]      byte to transmit, held until the next load
//   tx_busy           transmitter busy, no load while high
//   tx_done           transmitter finished the current byte
//   owner[1:0]        current grant holder
//   owner_valid       a grant is active (SEND, WAIT, HOLD)
//   timeout_err       one-cycle pulse when a grant is aborted
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned NREQ    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [1:0]        owner,
  output logic              owner_valid,
  output logic              timeout_err
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]    owner_n;
  logic [BYTE_W-1:0]   cur_data, cur_data_n;
  logic                cur_last, cur_last_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NREQ-1:0]     ack_n;
  logic                tx_start_n;
  logic [BYTE_W-1:0]   tx_data_n;
  logic                owner_valid_n;
  logic                timeout_err_n;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;
  logic                cnt_max;
  logic                hold_ready;

  assign cnt_max    = (cnt == CNT_W'(TIMEOUT));
  assign hold_ready = req[owner] && !tx_busy;

  // Round-robin search: first requester at or after rr_ptr. Scanning from the
  // farthest offset down lets the nearest one overwrite the result.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = rr_ptr + IDX_W'(i);
      if (req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (grant_found && !tx_busy) state_n = S_SEND;
      end
      S_SEND: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // tx_done outranks a timeout landing in the same cycle
        if (tx_done)      state_n = cur_last ? S_IDLE : S_HOLD;
        else if (cnt_max) state_n = S_IDLE;
      end
      S_HOLD: begin
        if (hold_ready)   state_n = S_SEND;
        else if (cnt_max) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output and datapath next values; all of these are registered below
  always_comb begin
    rr_ptr_n      = rr_ptr;
    owner_n       = owner;
    cur_data_n    = cur_data;
    cur_last_n    = cur_last;
    cnt_n         = cnt;
    ack_n         = '0;
    tx_start_n    = 1'b0;
    tx_data_n     = tx_data;
    timeout_err_n = 1'b0;
    owner_valid_n = (state_n != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant_found && !tx_busy) begin
          owner_n    = grant_idx;
          cur_data_n = req_data[{grant_idx, 3'b000} +: BYTE_W];
          cur_last_n = req_last[grant_idx];
        end
      end
      S_SEND: begin
        tx_start_n = 1'b1;
        ack_n      = NREQ'(1) << owner;
        tx_data_n  = cur_data;
        cnt_n      = '0;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (cur_last) rr_ptr_n = owner + IDX_W'(1);
          else          cnt_n    = '0;
        end else if (cnt_max) begin
          timeout_err_n = 1'b1;
          rr_ptr_n      = owner + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Packet lock: only the holder's next byte is considered
        if (hold_ready) begin
          cur_data_n = req_data[{owner, 3'b000} +: BYTE_W];
          cur_last_n = req_last[owner];
        end else if (cnt_max) begin
          timeout_err_n = 1'b1;
          rr_ptr_n      = owner + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      owner       <= '0;
      cur_data    <= '0;
      cur_last    <= 1'b0;
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      owner_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rr_ptr      <= rr_ptr_n;
      owner       <= owner_n;
      cur_data    <= cur_data_n;
      cur_last    <= cur_last_n;
      cnt         <= cnt_n;
      ack         <= ack_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      owner_valid <= owner_valid_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: drives four byte streams and a transmitter model into
// uart_tx_arbiter and compares every cycle against a deadline-based reference
// model of the arbitration rules, plus directed grant-order checks.
module tb_uart_tx_arbiter;

  localparam int TO = 4095;
  localparam int NR = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        timeout_err;

  uart_tx_arbiter #(.TIMEOUT(TO), .NREQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .owner      (owner),
    .owner_valid(owner_valid),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // requester byte streams
  logic [7:0] st_data [NR][64];
  bit         st_last [NR][64];
  int         st_gap  [NR][64];
  int         st_len  [NR];
  int         st_pos  [NR];
  int         gap_cnt [NR];

  // transmitter model and stimulus knobs
  bit tx_active, tx_nodone, tx_rand, noise_en;
  int tx_cnt, tx_delay, busy_until;

  // observations
  int glog[$];
  int first_start, first_req, n_timeouts;

  // reference model: pointer, lock, and absolute deadlines in cycle numbers
  int         m_ptr, m_lock, m_cur, m_wait_from, m_deadline, m_hold_deadline;
  bit         m_waiting, m_launch, m_last;
  logic [7:0] m_data, m_txdata;
  logic       e_tx_start, e_timeout, e_owner_valid;
  logic [3:0] e_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_cur = 0; m_waiting = 0; m_launch = 0; m_last = 0;
    m_data = 8'h00; m_txdata = 8'h00;
    m_wait_from = 0; m_deadline = 0; m_hold_deadline = 0;
  endtask

  // One rising edge of the arbitration rules, using the inputs present at it
  task automatic model_step();
    int cand;
    e_tx_start = 1'b0; e_ack = 4'h0; e_timeout = 1'b0;
    if (m_launch) begin
      e_tx_start = 1'b1;
      e_ack      = 4'(1) << m_cur;
      m_txdata   = m_data;
      m_launch   = 0;
    end
    if (!m_waiting) begin
      cand = -1;
      if (m_lock >= 0) begin
        if (req[m_lock]) cand = m_lock;
      end else begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (cand < 0 && req[j]) cand = j;
        end
      end
      if (cand >= 0 && !tx_busy) begin
        m_cur       = cand;
        m_data      = req_data[8*cand +: 8];
        m_last      = req_last[cand];
        m_launch    = 1;
        m_waiting   = 1;
        m_lock      = -1;
        m_wait_from = cyc + 2;
        m_deadline  = cyc + 2 + TO;
      end else if (m_lock >= 0 && cyc >= m_hold_deadline) begin
        e_timeout = 1'b1;
        m_ptr     = (m_lock + 1) % NR;
        m_lock    = -1;
      end
    end else if (cyc >= m_wait_from) begin
      if (tx_done) begin
        if (m_last) begin
          m_ptr = (m_cur + 1) % NR;
        end else begin
          m_lock          = m_cur;
          m_hold_deadline = cyc + 1 + TO;
        end
        m_waiting = 0;
      end else if (cyc >= m_deadline) begin
        e_timeout = 1'b1;
        m_ptr     = (m_cur + 1) % NR;
        m_waiting = 0;
      end
    end
    e_owner_valid = m_waiting || (m_lock >= 0);
  endtask

  task automatic clear_env();
    for (int i = 0; i < NR; i++) begin
      st_len[i] = 0; st_pos[i] = 0; gap_cnt[i] = 0;
    end
    tx_active = 0; tx_nodone = 0; tx_rand = 0; noise_en = 0;
    tx_cnt = 0; tx_delay = 10; busy_until = 0;
    glog.delete();
    first_start = -1; first_req = -1; n_timeouts = 0;
    req = 4'h0; req_data = 32'h0; req_last = 4'h0; tx_busy = 1'b0; tx_done = 1'b0;
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input bit l, input int g);
    if (st_len[i] == 0) gap_cnt[i] = g;
    st_data[i][st_len[i]] = d;
    st_last[i][st_len[i]] = l;
    st_gap[i][st_len[i]]  = g;
    st_len[i]++;
  endtask

  // Asserted mid-cycle: outputs must clear without waiting for an edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_owner_valid", 32'(owner_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    clear_env();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Inputs for the next edge
  task automatic drive();
    bit tb;
    for (int i = 0; i < NR; i++) begin
      if (st_pos[i] < st_len[i]) begin
        if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
          req[i] = 1'b0;
        end else begin
          req[i]             = 1'b1;
          req_data[8*i +: 8] = st_data[i][st_pos[i]];
          req_last[i]        = st_last[i][st_pos[i]];
        end
      end else begin
        req[i] = 1'b0;
      end
    end
    if (req != 4'h0 && first_req < 0) first_req = cyc;
    tx_done = 1'b0;
    tb      = 0;
    if (tx_active) begin
      tx_cnt--;
      tb = 1;
      if (tx_cnt <= 0) begin
        tx_active = 0;
        tx_done   = !tx_nodone;
      end
    end
    tx_busy = tb || (cyc + 1 < busy_until) || (noise_en && $urandom_range(0, 99) < 5);
    if (noise_en && !tb && $urandom_range(0, 99) < 3) tx_done = 1'b1;
  endtask

  task automatic run(input int ncyc);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      check("tx_start", 32'(tx_start), 32'(e_tx_start));
      check("ack", 32'(ack), 32'(e_ack));
      check("timeout_err", 32'(timeout_err), 32'(e_timeout));
      check("owner_valid", 32'(owner_valid), 32'(e_owner_valid));
      check("tx_data", 32'(tx_data), 32'(m_txdata));
      if (e_owner_valid) check("owner", 32'(owner), 32'(m_cur));
      if (tx_start) begin
        glog.push_back(int'(owner));
        if (first_start < 0) first_start = cyc;
        tx_active = 1;
        tx_cnt    = tx_nodone ? 5 : (tx_rand ? int'($urandom_range(2, 12)) : tx_delay);
      end
      if (timeout_err) n_timeouts++;
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && req[i] && st_pos[i] < st_len[i]) begin
          st_pos[i]++;
          if (st_pos[i] < st_len[i]) gap_cnt[i] = st_gap[i][st_pos[i]];
        end
      end
      drive();
    end
  endtask

  task automatic check_log(input string tag, input int exp_arr[8], input int exp_n);
    check({tag, "_len"}, 32'(glog.size()), 32'(exp_n));
    for (int k = 0; k < exp_n; k++) begin
      check(tag, (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(exp_arr[k]));
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_env();
    model_reset();
    repeat (2) @(posedge clk);

    // single requester, latency and data
    do_reset();
    add_byte(2, 8'hA5, 1, 0);
    run(25);
    check_log("single_grant", '{2, 0, 0, 0, 0, 0, 0, 0}, 1);
    check("single_latency", 32'(first_start - first_req), 32'd2);
    check("single_data", 32'(tx_data), 32'hA5);

    // all requesting, round-robin order
    do_reset();
    add_byte(0, 8'h10, 1, 0); add_byte(0, 8'h11, 1, 0);
    add_byte(1, 8'h21, 1, 0); add_byte(2, 8'h32, 1, 0); add_byte(3, 8'h43, 1, 0);
    run(80);
    check_log("rr_order", '{0, 1, 2, 3, 0, 0, 0, 0}, 5);

    // packet lock on requester 1
    do_reset();
    add_byte(0, 8'h01, 1, 0); add_byte(0, 8'h02, 1, 0);
    add_byte(1, 8'hB0, 0, 0); add_byte(1, 8'hB1, 0, 0); add_byte(1, 8'hB2, 1, 0);
    add_byte(3, 8'hD3, 1, 0);
    run(100);
    check_log("pkt_lock", '{0, 1, 1, 1, 3, 0, 0, 0}, 6);

    // transmitter busy holds off the grant
    do_reset();
    busy_until = cyc + 30;
    add_byte(0, 8'h5A, 1, 0);
    run(50);
    check("busy_hold_start", 32'(first_start), 32'(busy_until + 1));
    check_log("busy_grant", '{0, 0, 0, 0, 0, 0, 0, 0}, 1);

    // WAIT timeout then next requester
    do_reset();
    tx_nodone = 1;
    add_byte(0, 8'hC0, 1, 0); add_byte(1, 8'hC1, 1, 0);
    run(4300);
    check("wait_timeouts", 32'(n_timeouts), 32'd1);
    check_log("wait_to_grant", '{0, 1, 0, 0, 0, 0, 0, 0}, 2);

    // tx_done on the last cycle before the abort wins
    do_reset();
    tx_delay = TO + 1;
    add_byte(0, 8'hE0, 1, 0);
    run(4200);
    check("edge_timeouts", 32'(n_timeouts), 32'd0);
    check_log("edge_grant", '{0, 0, 0, 0, 0, 0, 0, 0}, 1);

    // silent holder in HOLD is aborted, others ignored meanwhile
    do_reset();
    add_byte(3, 8'h31, 0, 0); add_byte(3, 8'h32, 1, 6000);
    add_byte(1, 8'h11, 1, 20);
    run(4400);
    check("hold_timeouts", 32'(n_timeouts), 32'd1);
    check_log("hold_to_grant", '{3, 1, 0, 0, 0, 0, 0, 0}, 2);

    // reset in HOLD releases the lock; pointer restarts at 0
    do_reset();
    add_byte(3, 8'h77, 0, 0); add_byte(3, 8'h78, 1, 100);
    run(25);
    check("hold_pre_valid", 32'(owner_valid), 32'd1);
    check("hold_pre_owner", 32'(owner), 32'd3);
    do_reset();
    add_byte(0, 8'h90, 1, 0); add_byte(3, 8'h93, 1, 0);
    run(40);
    check_log("post_rst", '{0, 3, 0, 0, 0, 0, 0, 0}, 2);

    // randomized packets, gaps, delays, busy noise and stray tx_done
    do_reset();
    tx_rand  = 1;
    noise_en = 1;
    for (int i = 0; i < NR; i++) begin
      while (st_len[i] < 15) begin
        int plen;
        plen = int'($urandom_range(1, 3));
        for (int b = 0; b < plen; b++) begin
          add_byte(i, 8'($urandom), (b == plen - 1),
                   (b == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3)));
        end
      end
    end
    run(3000);
    for (int i = 0; i < NR; i++) check("rand_consumed", 32'(st_pos[i]), 32'(st_len[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
